// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and constants for the convolution offload engine.
package cnn_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_KER, FETCH, WRITE, FINISH} state_e;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 12;
    localparam int SAT_MAX    = 2 ** (DATA_W_DEF - 1) - 1;
    localparam int SAT_MIN    = -(2 ** (DATA_W_DEF - 1));

    // Headroom of 4 bits covers up to 16 full-scale products.
    function automatic int acc_width(input int data_w);
        return 2 * data_w + 4;
    endfunction

endpackage

// File: rtl/cnn_mac_sat.sv
// cnn_mac_sat: signed multiply-accumulate with clear, followed by an
// arithmetic shift, saturation to DATA_W and optional ReLU.
module cnn_mac_sat #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 2 * DATA_W + 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     first_i,
    input  logic signed [DATA_W-1:0] pix_i,
    input  logic signed [DATA_W-1:0] ker_i,
    input  logic [3:0]               shift_i,
    input  logic                     relu_i,
    output logic [DATA_W-1:0]        result_o
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_x, acc_q, acc_d, sh;
    logic [DATA_W-1:0]          sat;

    assign prod     = (2*DATA_W)'(pix_i) * (2*DATA_W)'(ker_i);
    assign prod_x   = ACC_W'(prod);
    // The first tap of an output overwrites rather than adds, so no separate clear cycle.
    assign acc_d    = en_i ? (first_i ? prod_x : acc_q + prod_x) : acc_q;
    assign sh       = acc_q >>> shift_i;
    assign sat      = sh > MAX_V ? MAX_V[DATA_W-1:0] : sh < MIN_V ? MIN_V[DATA_W-1:0] : sh[DATA_W-1:0];
    assign result_o = (relu_i && sat[DATA_W-1]) ? '0 : sat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
    end

endmodule

// File: rtl/cnn_conv_engine.sv
// cnn_conv_engine: KxK valid convolution over a single-channel image in
// shared memory; loads the kernel, streams pixels and writes the feature map.
module cnn_conv_engine
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int K      = 3,
    parameter int ACC_W  = acc_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] ker_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [7:0]        img_w,
    input  logic [7:0]        img_h,
    input  logic [3:0]        shift,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              write_en,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] to_memory,
    input  logic [DATA_W-1:0] from_memory,
    input  logic              mem_ready
);

    localparam int KW = $clog2(K + 1);

    state_e              state_q, state_d;
    logic                err_q, err_d, relu_q, relu_d;
    logic [ADDR_W-1:0]   img_base_q, img_base_d, ker_base_q, ker_base_d, out_base_q, out_base_d;
    logic [7:0]          img_w_q, img_w_d, img_h_q, img_h_d, ox_q, ox_d, oy_q, oy_d, ow;
    logic [3:0]          shift_q, shift_d, kidx;
    logic [KW-1:0]       kx_q, kx_d, ky_q, ky_d;
    logic                hs, last_kx, last_ky, last_ox, last_oy;
    logic [DATA_W-1:0]   result;
    logic signed [DATA_W-1:0] ker_q [16];

    assign busy      = state_q inside {LOAD_KER, FETCH, WRITE};
    assign mem_req   = busy;
    assign write_en  = state_q == WRITE;
    assign done      = state_q == FINISH;
    assign err       = done && err_q;
    assign hs        = mem_req && mem_ready;
    assign last_kx   = kx_q == KW'(K - 1);
    assign last_ky   = ky_q == KW'(K - 1);
    assign ow        = img_w_q - 8'(K - 1);
    assign last_ox   = ox_q == ow - 8'd1;
    assign last_oy   = oy_q == img_h_q - 8'(K);
    assign kidx      = 4'(int'(ky_q) * K + int'(kx_q));
    // Addresses derive from registered counters only, so they hold through stalls.
    assign address   = state_q == LOAD_KER ? ker_base_q + ADDR_W'(kidx)
                     : state_q == FETCH    ? img_base_q + (ADDR_W'(oy_q) + ADDR_W'(ky_q)) * ADDR_W'(img_w_q)
                                             + ADDR_W'(ox_q) + ADDR_W'(kx_q)
                     : state_q == WRITE    ? out_base_q + ADDR_W'(oy_q) * ADDR_W'(ow) + ADDR_W'(ox_q)
                     : '0;
    assign to_memory = write_en ? result : '0;

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        relu_d     = relu_q;
        img_base_d = img_base_q;
        ker_base_d = ker_base_q;
        out_base_d = out_base_q;
        img_w_d    = img_w_q;
        img_h_d    = img_h_q;
        shift_d    = shift_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        case (state_q)
            IDLE: if (start) begin
                if (img_w < 8'(K) || img_h < 8'(K)) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    err_d      = 1'b0;
                    relu_d     = relu_en;
                    img_base_d = img_base;
                    ker_base_d = ker_base;
                    out_base_d = out_base;
                    img_w_d    = img_w;
                    img_h_d    = img_h;
                    shift_d    = shift;
                    kx_d       = '0;
                    ky_d       = '0;
                    ox_d       = '0;
                    oy_d       = '0;
                    state_d    = LOAD_KER;
                end
            end
            LOAD_KER, FETCH: if (hs) begin
                kx_d = last_kx ? '0 : kx_q + 1'b1;
                ky_d = last_kx ? (last_ky ? '0 : ky_q + 1'b1) : ky_q;
                if (last_kx && last_ky) state_d = state_q == LOAD_KER ? FETCH : WRITE;
            end
            WRITE: if (hs) begin
                ox_d    = last_ox ? '0 : ox_q + 8'd1;
                oy_d    = last_ox ? oy_q + 8'd1 : oy_q;
                state_d = (last_ox && last_oy) ? FINISH : FETCH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            err_q      <= 1'b0;
            relu_q     <= 1'b0;
            img_base_q <= '0;
            ker_base_q <= '0;
            out_base_q <= '0;
            img_w_q    <= '0;
            img_h_q    <= '0;
            shift_q    <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            relu_q     <= relu_d;
            img_base_q <= img_base_d;
            ker_base_q <= ker_base_d;
            out_base_q <= out_base_d;
            img_w_q    <= img_w_d;
            img_h_q    <= img_h_d;
            shift_q    <= shift_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == LOAD_KER && hs) ker_q[kidx] <= from_memory;
    end

    cnn_mac_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk      (clk),
        .rst      (rst),
        .en_i     (state_q == FETCH && hs),
        .first_i  (kx_q == '0 && ky_q == '0),
        .pix_i    (from_memory),
        .ker_i    (ker_q[kidx]),
        .shift_i  (shift_q),
        .relu_i   (relu_q),
        .result_o (result)
    );

endmodule

// File: tb/tb_cnn_conv_engine.sv
// tb_cnn_conv_engine: directed and randomized runs of the convolution engine
// against a wait-state memory and a plain-arithmetic convolution model.
module tb_cnn_conv_engine;

    localparam int K = 3;

    logic        clk = 0, rst = 0, start = 0, relu_en = 0;
    logic [11:0] img_base = 0, ker_base = 0, out_base = 0;
    logic [7:0]  img_w = 0, img_h = 0;
    logic [3:0]  shift = 0;
    logic        busy, done, err, mem_req, write_en, mem_ready;
    logic [11:0] address;
    logic [15:0] to_memory, from_memory;

    logic [15:0] mem [4096];
    logic [11:0] wr_a [$];
    logic [15:0] wr_d [$];
    logic [11:0] exp_a [$];
    logic [15:0] exp_d [$];
    int cnt = 0, max_wait = 0, waits_total = 0, hs_count = 0;
    int vectors = 0, miscompares = 0;

    cnn_conv_engine #(.DATA_W(16), .ADDR_W(12), .K(K)) dut (
        .clk(clk), .rst(rst), .start(start),
        .img_base(img_base), .ker_base(ker_base), .out_base(out_base),
        .img_w(img_w), .img_h(img_h), .shift(shift), .relu_en(relu_en),
        .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .write_en(write_en), .address(address),
        .to_memory(to_memory), .from_memory(from_memory), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    assign mem_ready   = mem_req && cnt == 0;
    assign from_memory = mem[address];

    // Memory: each access stalls a random 0..max_wait cycles before ready.
    always @(posedge clk) begin
        if (mem_req && mem_ready) begin
            hs_count <= hs_count + 1;
            if (write_en) begin
                wr_a.push_back(address);
                wr_d.push_back(to_memory);
            end
            cnt <= $urandom_range(max_wait, 0);
        end else if (mem_req) begin
            cnt         <= cnt - 1;
            waits_total <= waits_total + 1;
        end else begin
            cnt <= $urandom_range(max_wait, 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [11:0] ib, kb, ob, input int w, h, sh, input logic rl);
        longint acc;
        exp_a.delete();
        exp_d.delete();
        for (int oy = 0; oy <= h - K; oy++)
            for (int ox = 0; ox <= w - K; ox++) begin
                acc = 0;
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        acc += longint'($signed(mem[12'(int'(ib) + (oy + ky) * w + ox + kx)]))
                             * longint'($signed(mem[12'(int'(kb) + ky * K + kx)]));
                acc = acc >>> sh;
                if (acc > 32767) acc = 32767;
                if (acc < -32768) acc = -32768;
                if (rl && acc < 0) acc = 0;
                exp_a.push_back(12'(int'(ob) + oy * (w - K + 1) + ox));
                exp_d.push_back(16'(acc));
            end
    endfunction

    task automatic run_job(input string tag, input logic [11:0] ib, kb, ob, input logic [7:0] w, h,
                           input logic [3:0] sh, input logic rl, input int mw, output int n0, output int cyc);
        int w0, nout;
        logic pst;
        logic [28:0] snap;
        model(ib, kb, ob, int'(w), int'(h), int'(sh), rl);
        nout     = (int'(w) - K + 1) * (int'(h) - K + 1);
        max_wait = mw;
        n0       = wr_a.size();
        @(negedge clk);
        img_base = ib; ker_base = kb; out_base = ob;
        img_w = w; img_h = h; shift = sh; relu_en = rl; start = 1;
        @(posedge clk);
        #1;
        start = 0;
        w0    = waits_total;
        img_base = 12'($urandom); ker_base = 12'($urandom); out_base = 12'($urandom);
        img_w = 8'($urandom); img_h = 8'($urandom); shift = 4'($urandom); relu_en = 1'($urandom);
        cyc = 1;
        pst = 0;
        snap = '0;
        chk({tag, " busy/mem_req cycle1"}, {30'd0, busy, mem_req}, 32'd3);
        while (done !== 1'b1 && cyc < 4000) begin
            if (pst && mem_req) chk({tag, " stall hold"}, {3'd0, address, write_en, to_memory}, {3'd0, snap});
            pst  = mem_req && !mem_ready;
            snap = {address, write_en, to_memory};
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, " done seen"}, {31'd0, done}, 32'd1);
        chk({tag, " done cycle"}, cyc, K * K + nout * (K * K + 1) + 1 + waits_total - w0);
        chk({tag, " err"}, {31'd0, err}, 32'd0);
        chk({tag, " write count"}, wr_a.size() - n0, exp_a.size());
        for (int i = 0; i < exp_a.size() && n0 + i < wr_a.size(); i++) begin
            chk({tag, " wr addr"}, {20'd0, wr_a[n0 + i]}, {20'd0, exp_a[i]});
            chk({tag, " wr data"}, {16'd0, wr_d[n0 + i]}, {16'd0, exp_d[i]});
        end
        @(posedge clk);
        #1;
        chk({tag, " idle after"}, {29'd0, done, busy, err}, 32'd0);
    endtask

    task automatic set_basic();
        for (int i = 0; i < 16; i++) mem[12'h100 + i] = 16'(i + 1);
        for (int i = 0; i < 9; i++)  mem[12'h040 + i] = 16'd1;
    endtask

    initial begin
        int n0, dc, hs0, wn;
        logic [15:0] basic_d [4];
        logic [11:0] wrap_a [4];
        basic_d = '{16'd54, 16'd63, 16'd90, 16'd99};
        wrap_a  = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        #1;
        chk("reset ctl", {27'd0, busy, done, err, mem_req, write_en}, 32'd0);
        chk("reset address", {20'd0, address}, 32'd0);
        chk("reset to_memory", {16'd0, to_memory}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;

        set_basic();
        run_job("basic", 12'h100, 12'h040, 12'h300, 8'd4, 8'd4, 4'd0, 1'b0, 0, n0, dc);
        chk("basic done cycle 50", dc, 50);
        for (int i = 0; i < 4; i++) chk("basic const", {16'd0, wr_d[n0 + i]}, {16'd0, basic_d[i]});

        for (int i = 0; i < 9; i++) begin mem[12'h100 + i] = 16'h7FFF; mem[12'h040 + i] = 16'h7FFF; end
        run_job("sat pos", 12'h100, 12'h040, 12'h310, 8'd3, 8'd3, 4'd0, 1'b0, 0, n0, dc);
        chk("sat pos const", {16'd0, wr_d[n0]}, 32'h7FFF);
        for (int i = 0; i < 9; i++) mem[12'h040 + i] = 16'hFFFF;
        run_job("sat neg", 12'h100, 12'h040, 12'h311, 8'd3, 8'd3, 4'd0, 1'b0, 0, n0, dc);
        chk("sat neg const", {16'd0, wr_d[n0]}, 32'h8000);
        run_job("relu", 12'h100, 12'h040, 12'h312, 8'd3, 8'd3, 4'd0, 1'b1, 0, n0, dc);
        chk("relu const", {16'd0, wr_d[n0]}, 32'h0000);

        set_basic();
        run_job("waits", 12'h100, 12'h040, 12'h320, 8'd4, 8'd4, 4'd0, 1'b0, 5, n0, dc);
        for (int i = 0; i < 4; i++) chk("waits const", {16'd0, wr_d[n0 + i]}, {16'd0, basic_d[i]});

        max_wait = 0;
        hs0 = hs_count;
        @(negedge clk);
        img_w = 8'd2; img_h = 8'd4; start = 1;
        @(posedge clk);
        #1;
        start = 0;
        chk("illegal cycle1", {28'd0, done, err, busy, mem_req}, 32'hC);
        @(posedge clk);
        #1;
        chk("illegal after", {28'd0, done, err, busy, mem_req}, 32'h0);
        chk("illegal no access", hs_count, hs0);

        run_job("wrap", 12'h100, 12'h040, 12'hFFE, 8'd4, 8'd4, 4'd0, 1'b0, 0, n0, dc);
        for (int i = 0; i < 4; i++) chk("wrap addr", {20'd0, wr_a[n0 + i]}, {20'd0, wrap_a[i]});

        n0 = wr_a.size();
        @(negedge clk);
        img_base = 12'h100; ker_base = 12'h040; out_base = 12'h330;
        img_w = 8'd4; img_h = 8'd4; shift = 0; relu_en = 0; start = 1;
        @(posedge clk);
        #1;
        start = 0;
        for (int i = 0; i < 200 && wr_a.size() == n0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        rst = 0;
        #1;
        chk("async reset ctl", {27'd0, busy, done, err, mem_req, write_en}, 32'd0);
        chk("async reset addr/data", {4'd0, address, to_memory}, 32'd0);
        chk("reset first write only", wr_a.size() - n0, 1);
        chk("reset first write data", {16'd0, wr_d[n0]}, 32'd54);
        hs0 = hs_count;
        wn  = wr_a.size();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("post-reset no access", hs_count, hs0);
        chk("post-reset no write", wr_a.size(), wn);
        chk("post-reset idle", {30'd0, busy, mem_req}, 32'd0);
        run_job("restart", 12'h100, 12'h040, 12'h340, 8'd4, 8'd4, 4'd0, 1'b0, 0, n0, dc);

        for (int t = 0; t < 6; t++) begin
            logic [7:0] w, h;
            w = 8'($urandom_range(6, 3));
            h = 8'($urandom_range(6, 3));
            for (int i = 0; i < 36; i++) mem[12'h100 + i] = 16'($urandom);
            for (int i = 0; i < 9; i++)
                mem[12'h040 + i] = t[0] ? 16'($urandom) : 16'($signed($urandom_range(15, 0)) - 8);
            run_job("random", 12'h100, 12'h040, 12'h380, w, h, 4'($urandom_range(15, 0)),
                    1'($urandom), $urandom_range(3, 0), n0, dc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
